// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types for the stall/flush controller of the 5-stage in-order pipeline.
//   SB_DEPTH   : scoreboard entries (EX, MEM, WB)
//   SB_RD_W    : stored register-address width; instances must use REG_AW <= SB_RD_W
//   sb_entry_t : one scoreboard entry {valid, destination register}
//   hz_cause_e : winning cause of the output priority mux, also used by the
//                optional perf counters (HAZARD_PERF_EN)
// -----------------------------------------------------------------------------
package hazard_pkg;

    localparam int SB_DEPTH = 3;
    localparam int SB_RD_W  = 5;

    typedef struct packed {
        logic               v;
        logic [SB_RD_W-1:0] rd;
    } sb_entry_t;

    typedef enum logic [1:0] {
        HZ_NONE,
        HZ_RAW,
        HZ_REDIRECT,
        HZ_FREEZE
    } hz_cause_e;

    // Entry matches a source register when it is valid and names that register.
    function automatic logic sb_match(input sb_entry_t e, input logic [SB_RD_W-1:0] r);
        return e.v && (e.rd == r);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if
// Decode-stage / redirect / memory back-pressure inputs and pipeline-register
// control outputs of hazard_ctrl.
//   master : pipeline side, drives id_*, ex_redirect_i, mem_busy_i
//   slave  : hazard_ctrl side, drives the stall/clear/freeze controls
// -----------------------------------------------------------------------------
interface hazard_ctrl_if #(
    parameter int REG_AW = 5
);
    logic              id_valid_i;
    logic [REG_AW-1:0] id_rs1_i;
    logic [REG_AW-1:0] id_rs2_i;
    logic              id_use_rs1_i;
    logic              id_use_rs2_i;
    logic [REG_AW-1:0] id_rd_i;
    logic              id_wr_en_i;
    logic              ex_redirect_i;
    logic              mem_busy_i;

    logic              pc_stall_o;
    logic              fd_stall_o;
    logic              fd_clear_o;
    logic              de_stall_o;
    logic              de_clear_o;
    logic              freeze_o;

    modport master (
        output id_valid_i, id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
               id_rd_i, id_wr_en_i, ex_redirect_i, mem_busy_i,
        input  pc_stall_o, fd_stall_o, fd_clear_o, de_stall_o, de_clear_o, freeze_o
    );

    modport slave (
        input  id_valid_i, id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
               id_rd_i, id_wr_en_i, ex_redirect_i, mem_busy_i,
        output pc_stall_o, fd_stall_o, fd_clear_o, de_stall_o, de_clear_o, freeze_o
    );

endinterface

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
// Shift register of destination registers in flight (r_sb[0]=EX, [1]=MEM,
// [2]=WB) plus the hit comparators for both ID source operands.
// Ports:
//   clk_i, rst_ni        : clock, async active-low reset (clears all valids)
//   i_advance            : shift this edge (low while memory is busy)
//   i_push_v, i_push_rd  : entry entering EX
//   i_rs1, i_rs2         : ID source addresses to look up
//   o_hit_rs1, o_hit_rs2 : a checked entry holds that register
// CHECK_WB=1 also checks the WB entry (register file without write-before-read).
// -----------------------------------------------------------------------------
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int CHECK_WB = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              i_advance,
    input  logic              i_push_v,
    input  logic [REG_AW-1:0] i_push_rd,
    input  logic [REG_AW-1:0] i_rs1,
    input  logic [REG_AW-1:0] i_rs2,
    output logic              o_hit_rs1,
    output logic              o_hit_rs2
);

    localparam int N_CHECK = (CHECK_WB != 0) ? SB_DEPTH : SB_DEPTH - 1;

    sb_entry_t          r_sb [SB_DEPTH];
    logic [SB_RD_W-1:0] w_rs1;
    logic [SB_RD_W-1:0] w_rs2;

    assign w_rs1 = SB_RD_W'(i_rs1);
    assign w_rs2 = SB_RD_W'(i_rs2);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < SB_DEPTH; i++) begin
                r_sb[i] <= '0;
            end
        end else if (i_advance) begin
            r_sb[0].v  <= i_push_v;
            r_sb[0].rd <= SB_RD_W'(i_push_rd);
            for (int i = 1; i < SB_DEPTH; i++) begin
                r_sb[i] <= r_sb[i-1];
            end
        end
    end

    always_comb begin
        o_hit_rs1 = 1'b0;
        o_hit_rs2 = 1'b0;
        for (int i = 0; i < N_CHECK; i++) begin
            if (sb_match(r_sb[i], w_rs1)) o_hit_rs1 = 1'b1;
            if (sb_match(r_sb[i], w_rs2)) o_hit_rs2 = 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Stall/flush controller for the 5-stage in-order pipeline without forwarding.
// Ports:
//   clk_i, rst_ni : clock, async active-low reset
//   bus (slave)   : ID operand info, EX redirect, memory busy in;
//                   PC / F-D / D-E stall+clear and E-M / M-W freeze out
// Optional (macro HAZARD_PERF_EN):
//   raw_stall_cnt_o, flush_cnt_o, freeze_cnt_o : 32-bit cycle counters of each
//   active priority case, async reset, wrapping.
// Priority: mem busy (freeze) > EX redirect (flush) > RAW (stall + bubble).
// All controls are combinational; while in reset both clears are forced high.
// -----------------------------------------------------------------------------
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int CHECK_WB = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    hazard_ctrl_if.slave bus
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] raw_stall_cnt_o,
    output logic [31:0] flush_cnt_o,
    output logic [31:0] freeze_cnt_o
`endif
);

    logic      w_hit_rs1;
    logic      w_hit_rs2;
    logic      w_raw;
    logic      w_push_v;
    logic      w_advance;
    hz_cause_e w_cause;

    // x0 is hardwired zero: never a dependency, never tracked.
    assign w_raw = bus.id_valid_i &
                   ((bus.id_use_rs1_i & (bus.id_rs1_i != '0) & w_hit_rs1) |
                    (bus.id_use_rs2_i & (bus.id_rs2_i != '0) & w_hit_rs2));

    // A stalled or wrong-path instruction does not enter EX, so a bubble is pushed.
    assign w_push_v  = bus.id_valid_i & bus.id_wr_en_i & (bus.id_rd_i != '0) &
                       ~w_raw & ~bus.ex_redirect_i;
    assign w_advance = ~bus.mem_busy_i;

    hazard_scoreboard #(
        .REG_AW   (REG_AW),
        .CHECK_WB (CHECK_WB)
    ) u_sb (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .i_advance (w_advance),
        .i_push_v  (w_push_v),
        .i_push_rd (bus.id_rd_i),
        .i_rs1     (bus.id_rs1_i),
        .i_rs2     (bus.id_rs2_i),
        .o_hit_rs1 (w_hit_rs1),
        .o_hit_rs2 (w_hit_rs2)
    );

    // A redirect under busy is deliberately dropped: EX is frozen and will
    // present it again once memory is ready.
    always_comb begin
        w_cause = HZ_NONE;
        if (bus.mem_busy_i) begin
            w_cause = HZ_FREEZE;
        end else if (bus.ex_redirect_i) begin
            w_cause = HZ_REDIRECT;
        end else if (w_raw) begin
            w_cause = HZ_RAW;
        end
    end

    always_comb begin
        bus.pc_stall_o = 1'b0;
        bus.fd_stall_o = 1'b0;
        bus.fd_clear_o = 1'b0;
        bus.de_stall_o = 1'b0;
        bus.de_clear_o = 1'b0;
        bus.freeze_o   = 1'b0;
        if (!rst_ni) begin
            bus.fd_clear_o = 1'b1;
            bus.de_clear_o = 1'b1;
        end else begin
            case (w_cause)
                HZ_FREEZE: begin
                    bus.pc_stall_o = 1'b1;
                    bus.fd_stall_o = 1'b1;
                    bus.de_stall_o = 1'b1;
                    bus.freeze_o   = 1'b1;
                end
                HZ_REDIRECT: begin
                    bus.fd_clear_o = 1'b1;
                    bus.de_clear_o = 1'b1;
                end
                HZ_RAW: begin
                    bus.pc_stall_o = 1'b1;
                    bus.fd_stall_o = 1'b1;
                    bus.de_clear_o = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] r_raw_cnt;
    logic [31:0] r_flush_cnt;
    logic [31:0] r_freeze_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_raw_cnt    <= '0;
            r_flush_cnt  <= '0;
            r_freeze_cnt <= '0;
        end else begin
            case (w_cause)
                HZ_RAW:      r_raw_cnt    <= r_raw_cnt + 32'd1;
                HZ_REDIRECT: r_flush_cnt  <= r_flush_cnt + 32'd1;
                HZ_FREEZE:   r_freeze_cnt <= r_freeze_cnt + 32'd1;
                default: ;
            endcase
        end
    end

    assign raw_stall_cnt_o = r_raw_cnt;
    assign flush_cnt_o     = r_flush_cnt;
    assign freeze_cnt_o    = r_freeze_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Two controllers (CHECK_WB=1 and CHECK_WB=0) see identical stimulus; each
// vector carries the expected controls for both. Output packing:
// {pc_stall, fd_stall, fd_clear, de_stall, de_clear, freeze}.
module tb_hazard_ctrl;

    localparam logic [5:0] O_N = 6'b000000;   // idle
    localparam logic [5:0] O_R = 6'b110010;   // raw stall + bubble
    localparam logic [5:0] O_F = 6'b001010;   // redirect flush (also reset)
    localparam logic [5:0] O_Z = 6'b110101;   // memory freeze

    typedef struct {
        logic       rst_n;
        logic       valid;
        logic [4:0] rs1;
        logic       use1;
        logic [4:0] rs2;
        logic       use2;
        logic [4:0] rd;
        logic       wr;
        logic       redir;
        logic       busy;
        logic [5:0] exp1;
        logic [5:0] exp0;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_fail = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_AW(5)) if1 ();
    hazard_ctrl_if #(.REG_AW(5)) if0 ();

`ifdef HAZARD_PERF_EN
    logic [31:0] raw1, flush1, frz1, raw0, flush0, frz0;
`endif

    hazard_ctrl #(.REG_AW(5), .CHECK_WB(1)) u_dut1 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (if1)
`ifdef HAZARD_PERF_EN
        , .raw_stall_cnt_o (raw1), .flush_cnt_o (flush1), .freeze_cnt_o (frz1)
`endif
    );

    hazard_ctrl #(.REG_AW(5), .CHECK_WB(0)) u_dut0 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (if0)
`ifdef HAZARD_PERF_EN
        , .raw_stall_cnt_o (raw0), .flush_cnt_o (flush0), .freeze_cnt_o (frz0)
`endif
    );

    function automatic vec_t mk(input logic r, input logic v, input logic [4:0] s1, input logic u1,
                                input logic [4:0] s2, input logic u2, input logic [4:0] d,
                                input logic w, input logic rdr, input logic b,
                                input logic [5:0] e1, input logic [5:0] e0);
        vec_t t;
        t.rst_n = r; t.valid = v; t.rs1 = s1; t.use1 = u1; t.rs2 = s2; t.use2 = u2;
        t.rd = d; t.wr = w; t.redir = rdr; t.busy = b; t.exp1 = e1; t.exp0 = e0;
        return t;
    endfunction

    task automatic drive(input vec_t t);
        rst_n = t.rst_n;
        if1.id_valid_i = t.valid;  if0.id_valid_i = t.valid;
        if1.id_rs1_i = t.rs1;      if0.id_rs1_i = t.rs1;
        if1.id_rs2_i = t.rs2;      if0.id_rs2_i = t.rs2;
        if1.id_use_rs1_i = t.use1; if0.id_use_rs1_i = t.use1;
        if1.id_use_rs2_i = t.use2; if0.id_use_rs2_i = t.use2;
        if1.id_rd_i = t.rd;        if0.id_rd_i = t.rd;
        if1.id_wr_en_i = t.wr;     if0.id_wr_en_i = t.wr;
        if1.ex_redirect_i = t.redir; if0.ex_redirect_i = t.redir;
        if1.mem_busy_i = t.busy;   if0.mem_busy_i = t.busy;
    endtask

    function automatic logic [5:0] out1();
        return {if1.pc_stall_o, if1.fd_stall_o, if1.fd_clear_o,
                if1.de_stall_o, if1.de_clear_o, if1.freeze_o};
    endfunction

    function automatic logic [5:0] out0();
        return {if0.pc_stall_o, if0.fd_stall_o, if0.fd_clear_o,
                if0.de_stall_o, if0.de_clear_o, if0.freeze_o};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        int m_raw1 = 0, m_fl1 = 0, m_fz1 = 0, m_raw0 = 0, m_fl0 = 0, m_fz0 = 0;

        //            rst v  rs1 u1 rs2 u2 rd wr rdr busy  wb1  wb0
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_F, O_F));  // 0  in reset
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 5, 1, 0, 0, O_N, O_N));  // 1  writer x5
        vecs.push_back(mk(1, 1, 5, 1, 0, 0, 0, 0, 0, 0, O_R, O_R));  // 2  x5 in EX
        vecs.push_back(mk(1, 1, 5, 1, 0, 0, 0, 0, 0, 0, O_R, O_R));  // 3  x5 in MEM
        vecs.push_back(mk(1, 1, 5, 1, 0, 0, 0, 0, 0, 0, O_R, O_N));  // 4  x5 in WB
        vecs.push_back(mk(1, 1, 5, 1, 0, 0, 0, 0, 0, 0, O_N, O_N));  // 5  retired
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, O_N, O_N));  // 6  writer x0
        vecs.push_back(mk(1, 1, 0, 1, 0, 1, 0, 0, 0, 0, O_N, O_N));  // 7  reads x0
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 7, 1, 0, 0, O_N, O_N));  // 8  writer x7
        vecs.push_back(mk(1, 1, 0, 0, 7, 1, 9, 1, 1, 0, O_F, O_F));  // 9  raw x7 + redirect
        vecs.push_back(mk(1, 1, 9, 1, 0, 0, 0, 0, 0, 0, O_N, O_N));  // 10 x9 not tracked
        vecs.push_back(mk(1, 1, 0, 0, 7, 1, 0, 0, 0, 0, O_R, O_N));  // 11 x7 in WB via rs2
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 3, 1, 0, 0, O_N, O_N));  // 12 writer x3
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, O_N, O_N));  // 13 filler
        vecs.push_back(mk(1, 1, 3, 1, 0, 0, 0, 0, 0, 1, O_Z, O_Z));  // 14 busy, x3 in MEM
        vecs.push_back(mk(1, 1, 3, 1, 0, 0, 0, 0, 0, 1, O_Z, O_Z));  // 15
        vecs.push_back(mk(1, 1, 3, 1, 0, 0, 0, 0, 0, 1, O_Z, O_Z));  // 16
        vecs.push_back(mk(1, 1, 3, 1, 0, 0, 0, 0, 0, 1, O_Z, O_Z));  // 17
        vecs.push_back(mk(1, 1, 3, 1, 0, 0, 0, 0, 0, 0, O_R, O_R));  // 18 x3 still in MEM
        vecs.push_back(mk(1, 1, 3, 1, 0, 0, 0, 0, 0, 0, O_R, O_N));  // 19 x3 in WB
        vecs.push_back(mk(1, 1, 3, 1, 0, 0, 0, 0, 0, 0, O_N, O_N));  // 20
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 1, O_Z, O_Z));  // 21 busy beats redirect
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, O_F, O_F));  // 22 redirect re-presented
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 5, 1, 0, 0, O_N, O_N));  // 23 writer x5
        vecs.push_back(mk(1, 1, 5, 1, 0, 0, 0, 0, 0, 0, O_R, O_R));  // 24 raw stall
        vecs.push_back(mk(0, 1, 5, 1, 0, 0, 0, 0, 0, 0, O_F, O_F));  // 25 reset mid-stall
        vecs.push_back(mk(1, 1, 5, 1, 0, 0, 0, 0, 0, 0, O_N, O_N));  // 26 sb empty
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 4, 1, 0, 0, O_N, O_N));  // 27 writer x4
        vecs.push_back(mk(1, 0, 0, 0, 4, 1, 0, 0, 0, 0, O_N, O_N));  // 28 not valid
        vecs.push_back(mk(1, 1, 0, 1, 4, 0, 0, 0, 0, 0, O_N, O_N));  // 29 rs2 unused
        vecs.push_back(mk(1, 1, 0, 0, 4, 1, 0, 0, 0, 0, O_R, O_N));  // 30 x4 in WB

        drive(vecs[0]);
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            drive(vecs[i]);
            @(negedge clk);
            check($sformatf("v%0d_wb1", i), 32'(out1()), 32'(vecs[i].exp1));
            check($sformatf("v%0d_wb0", i), 32'(out0()), 32'(vecs[i].exp0));
            if (!vecs[i].rst_n) begin
                m_raw1 = 0; m_fl1 = 0; m_fz1 = 0; m_raw0 = 0; m_fl0 = 0; m_fz0 = 0;
            end else begin
                if (vecs[i].exp1 == O_R) m_raw1++;
                if (vecs[i].exp1 == O_F) m_fl1++;
                if (vecs[i].exp1 == O_Z) m_fz1++;
                if (vecs[i].exp0 == O_R) m_raw0++;
                if (vecs[i].exp0 == O_F) m_fl0++;
                if (vecs[i].exp0 == O_Z) m_fz0++;
            end
        end

        @(posedge clk); #1;
`ifdef HAZARD_PERF_EN
        check("raw_cnt_wb1", raw1, 32'(m_raw1));
        check("flush_cnt_wb1", flush1, 32'(m_fl1));
        check("freeze_cnt_wb1", frz1, 32'(m_fz1));
        check("raw_cnt_wb0", raw0, 32'(m_raw0));
        check("flush_cnt_wb0", flush0, 32'(m_fl0));
        check("freeze_cnt_wb0", frz0, 32'(m_fz0));
`endif

        // Short reset pulse that spans no clock edge must still empty the scoreboard.
        drive(mk(1, 1, 0, 0, 0, 0, 6, 1, 0, 0, O_N, O_N));
        @(posedge clk); #1;
        drive(mk(1, 1, 6, 1, 0, 0, 0, 0, 0, 0, O_R, O_R));
        #1;
        check("pre_pulse_wb1", 32'(out1()), 32'(O_R));
        check("pre_pulse_wb0", 32'(out0()), 32'(O_R));
        rst_n = 1'b0;
        #1;
        check("in_pulse_wb1", 32'(out1()), 32'(O_F));
        check("in_pulse_wb0", 32'(out0()), 32'(O_F));
        rst_n = 1'b1;
        @(negedge clk);
        check("post_pulse_wb1", 32'(out1()), 32'(O_N));
        check("post_pulse_wb0", 32'(out0()), 32'(O_N));
`ifdef HAZARD_PERF_EN
        check("cnt_zero_raw", raw1, 32'd0);
        check("cnt_zero_flush", flush1, 32'd0);
        check("cnt_zero_freeze", frz1, 32'd0);
`endif
        @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Stall/flush controller for the 5-stage in-order pipeline, which has no forwarding network.
- Keeps its own scoreboard of destination registers in flight in EX, MEM and WB.
- Detects RAW hazards on the instruction in ID and handles EX-resolved branch/jump redirects and data-memory back-pressure.
- Drives the stall (active-high hold) and clear inputs of the PC, F/D and D/E pipeline registers, plus a global freeze for E/M and M/W.

Parameters:
- REG_AW, 5, register-address width.
- CHECK_WB, 1, 1 = register file has no write-before-read, so the WB entry is also checked; 0 = only EX/MEM entries are checked.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- id_valid_i  in  1  ID holds a real instruction
- id_rs1_i  in  REG_AW  source 1 address
- id_rs2_i  in  REG_AW  source 2 address
- id_use_rs1_i  in  1  instruction reads rs1
- id_use_rs2_i  in  1  instruction reads rs2
- id_rd_i  in  REG_AW  destination address
- id_wr_en_i  in  1  instruction writes rd
- ex_redirect_i  in  1  branch taken / jump resolved in EX this cycle
- mem_busy_i  in  1  data memory not ready; whole pipeline must hold
- pc_stall_o  out  1  hold PC
- fd_stall_o  out  1  F/D enable_ni (1 = hold)
- fd_clear_o  out  1  F/D clear
- de_stall_o  out  1  D/E hold
- de_clear_o  out  1  D/E clear (inject bubble)
- freeze_o  out  1  hold E/M and M/W

Behaviour:
- Scoreboard
  - 3 entries {v, rd}: sb[0]=EX, sb[1]=MEM, sb[2]=WB.
  - On reset all v=0, asynchronously.
- Hazard term (combinational)
  - raw = id_valid_i & ((id_use_rs1_i & rs1!=0 & hit(rs1)) | (id_use_rs2_i & rs2!=0 & hit(rs2))).
  - hit(r) = OR over checked entries of (v & rd==r).
  - Checked entries: sb[0..2] when CHECK_WB=1, sb[0..1] when CHECK_WB=0.
- Output priority, highest first:
  1. mem_busy_i: freeze_o=pc_stall_o=fd_stall_o=de_stall_o=1, clears 0. Scoreboard holds. A pending ex_redirect_i is not acted on; EX is frozen, so it is re-presented after busy drops.
  2. ex_redirect_i: fd_clear_o=de_clear_o=1, stalls 0. raw is ignored because the ID instruction is wrong-path.
  3. raw: pc_stall_o=fd_stall_o=1, de_clear_o=1 (bubble), others 0.
  4. Otherwise all outputs 0.
- Scoreboard update on each clk edge when mem_busy_i=0:
  - sb[2]<=sb[1]; sb[1]<=sb[0].
  - sb[0] <= {id_valid_i & id_wr_en_i & id_rd_i!=0 & !raw & !ex_redirect_i, id_rd_i}.
  - Writes to x0 are never tracked.
- Stall latency
  - Dependent instruction immediately behind a writer stalls 3 cycles when CHECK_WB=1, 2 when CHECK_WB=0.
  - Stall drops the same cycle the matching entry retires.
- Outputs are combinational from scoreboard state and inputs; no registered output latency.
- While rst_ni=0: fd_clear_o=de_clear_o=1, all stalls and freeze_o=0.
- Reset deasserted mid-stall: scoreboard is empty, so the stall ends immediately.
- Simultaneous raw and mem_busy_i: freeze wins. raw is re-evaluated after busy, with the unchanged scoreboard.

Optional Feature:
- Macro HAZARD_PERF_EN.
- When defined, adds outputs raw_stall_cnt_o[31:0], flush_cnt_o[31:0], freeze_cnt_o[31:0].
  - Each counts cycles in which its priority case is active.
  - Async reset to 0; wraps at 2^32.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package hazard_pkg:
  - typedef sb_entry_t {logic v; logic [REG_AW-1:0] rd}
  - localparam SB_DEPTH=3
  - enum hz_cause_e {HZ_NONE, HZ_RAW, HZ_REDIRECT, HZ_FREEZE}, used by the priority mux and the perf counters.
- One natural sub-module: hazard_scoreboard, holding the shift register and hit() comparators.
- Priority and output logic stay in hazard_ctrl.

Test Plan:
- Writer x5 issued, next instr reads x5, CHECK_WB=1 -> pc_stall_o/fd_stall_o/de_clear_o high for 3 cycles, then 0; scoreboard advances bubbles.
- Same as above with CHECK_WB=0 -> stall for exactly 2 cycles.
- Writer rd=x0, next instr reads x0 -> no stall.
- ex_redirect_i=1 while ID has a raw hit on x7 -> fd_clear_o=de_clear_o=1, stalls 0; ID instr not entered in sb[0].
- mem_busy_i=1 for 4 cycles with x3 in sb[1] and ID reading x3 -> freeze outputs all 1 for 4 cycles, scoreboard unchanged; then raw stall resumes for its remaining 2 cycles.
- rst_ni pulsed low during a raw stall -> sb cleared asynchronously, clears=1 during reset, stalls 0 after release; with HAZARD_PERF_EN all counters read 0.
